// File: rtl/stack_unit_if.sv
// Push/pop bus between the control unit (master) and the operand stack (slave).
// Optional next-on-stack signals are present when STACK_NOS_EN is defined.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             clear_err;
  logic [WIDTH-1:0] tos;
  logic             tos_zero;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;
`ifdef STACK_NOS_EN
  logic [WIDTH-1:0] nos;
  logic             two_valid;
`endif

`ifdef STACK_NOS_EN
  modport master (
    output push, pop, din, clear_err,
    input  tos, tos_zero, empty, full, count, overflow, underflow, nos, two_valid
  );
  modport slave (
    input  push, pop, din, clear_err,
    output tos, tos_zero, empty, full, count, overflow, underflow, nos, two_valid
  );
`else
  modport master (
    output push, pop, din, clear_err,
    input  tos, tos_zero, empty, full, count, overflow, underflow
  );
  modport slave (
    input  push, pop, din, clear_err,
    output tos, tos_zero, empty, full, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/stack_unit.sv
// Hardware operand stack for the multicycle stack-machine datapath.
// LIFO of DEPTH x WIDTH words with occupancy count, full/empty decode and
// sticky overflow/underflow flags. Top of stack is read combinationally.
// Optional macro STACK_NOS_EN adds the next-on-stack outputs nos/two_valid.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  stack_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             empty_s;
  logic             full_s;
  logic [AW-1:0]    top_idx_s;
  logic [WIDTH-1:0] tos_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;

  // When full the low AW bits of count wrap to 0, so subtracting 1 still
  // lands on DEPTH-1; when empty the index is unused because tos is gated.
  assign empty_s   = (count_q == ZERO_CNT);
  assign full_s    = (count_q == FULL_CNT);
  assign top_idx_s = count_q[AW-1:0] - AW'(1);

  // Top-of-stack read path, forced to zero when nothing is stored.
  always_comb begin
    tos_s = {WIDTH{1'b0}};
    if (!empty_s) begin
      tos_s = mem_q[top_idx_s];
    end else begin
      tos_s = {WIDTH{1'b0}};
    end
  end

  // Next-state decode for count, storage write and sticky error flags.
  always_comb begin
    count_d     = count_q;
    wr_en_s     = 1'b0;
    wr_addr_s   = count_q[AW-1:0];
    // Clear first so that an error raised in the same cycle wins.
    if (bus.clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
    end
    case ({bus.push, bus.pop})
      2'b10: begin
        if (!full_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = count_q[AW-1:0];
          count_d   = count_q + ONE_CNT;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          count_d = count_q - ONE_CNT;
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        // Fused pop-operate-push: overwrite the top in place; never overflows.
        if (!empty_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = top_idx_s;
        end else begin
          underflow_d = 1'b1;
          wr_en_s     = 1'b1;
          wr_addr_s   = {AW{1'b0}};
          count_d     = ONE_CNT;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Control state: occupancy and sticky flags, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= ZERO_CNT;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are not reset since they are hidden while empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= bus.din;
    end
  end

  assign bus.tos       = tos_s;
  assign bus.tos_zero  = !empty_s && (tos_s == {WIDTH{1'b0}});
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef STACK_NOS_EN
  logic             two_valid_s;
  logic [AW-1:0]    nos_idx_s;
  logic [WIDTH-1:0] nos_s;

  assign two_valid_s = (count_q >= CNT_W'(2));
  assign nos_idx_s   = count_q[AW-1:0] - AW'(2);

  // Next-on-stack read path, valid only with at least two entries.
  always_comb begin
    nos_s = {WIDTH{1'b0}};
    if (two_valid_s) begin
      nos_s = mem_q[nos_idx_s];
    end else begin
      nos_s = {WIDTH{1'b0}};
    end
  end

  assign bus.nos       = nos_s;
  assign bus.two_valid = two_valid_s;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (DEPTH=16, WIDTH=8).
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  stack_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_if ();

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.push      = 1'b0;
    u_if.pop       = 1'b0;
    u_if.din       = 8'h00;
    u_if.clear_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic push_val(input logic [7:0] v);
    u_if.push = 1'b1;
    u_if.din  = v;
    tick();
    idle_inputs();
  endtask

  task automatic pop_one();
    u_if.pop = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({u_if.count, u_if.empty, u_if.full, u_if.tos, u_if.tos_zero, u_if.overflow, u_if.underflow}
        !== {5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b tos=%h tz=%b ovf=%b unf=%b expected 0,1,0,00,0,0,0",
               u_if.count, u_if.empty, u_if.full, u_if.tos, u_if.tos_zero, u_if.overflow, u_if.underflow);
    end
    push_val(8'h01);
    push_val(8'h02);
    push_val(8'h03);
    tests_run++;
    if (u_if.count !== 5'd3) begin
      tests_failed++;
      $display("FAIL reset_precount: count=%0d expected 3", u_if.count);
    end
    // Assert reset in the middle of a push, away from the clock edge.
    u_if.push = 1'b1;
    u_if.din  = 8'h44;
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({u_if.count, u_if.empty, u_if.tos, u_if.overflow, u_if.underflow}
        !== {5'd0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_midop: count=%0d empty=%b tos=%h ovf=%b unf=%b expected 0,1,00,0,0",
               u_if.count, u_if.empty, u_if.tos, u_if.overflow, u_if.underflow);
    end
    idle_inputs();
    tick();
    reset_n = 1'b1;
    pop_one();
    tests_run++;
    if ({u_if.underflow, u_if.count} !== {1'b1, 5'd0}) begin
      tests_failed++;
      $display("FAIL reset_pop_underflow: unf=%b count=%0d expected 1,0", u_if.underflow, u_if.count);
    end
  endtask

  task automatic test_lifo();
    logic [7:0] exp_tos [3];
    exp_tos[0] = 8'h33;
    exp_tos[1] = 8'h22;
    exp_tos[2] = 8'h11;
    do_reset();
    push_val(8'h11);
    push_val(8'h22);
    push_val(8'h33);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({u_if.tos, u_if.count} !== {exp_tos[i], 5'(3 - i)}) begin
        tests_failed++;
        $display("FAIL lifo_pop%0d: tos=%h count=%0d expected %h,%0d", i, u_if.tos, u_if.count, exp_tos[i], 3 - i);
      end
      pop_one();
    end
    tests_run++;
    if ({u_if.count, u_if.empty, u_if.underflow} !== {5'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL lifo_end: count=%0d empty=%b unf=%b expected 0,1,0", u_if.count, u_if.empty, u_if.underflow);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_val(8'(i));
    end
    tests_run++;
    if ({u_if.full, u_if.count, u_if.tos, u_if.overflow} !== {1'b1, 5'd16, 8'h0F, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_reached: full=%b count=%0d tos=%h ovf=%b expected 1,16,0f,0",
               u_if.full, u_if.count, u_if.tos, u_if.overflow);
    end
    push_val(8'hAA);
    tests_run++;
    if ({u_if.full, u_if.count, u_if.tos, u_if.overflow} !== {1'b1, 5'd16, 8'h0F, 1'b1}) begin
      tests_failed++;
      $display("FAIL overflow_push: full=%b count=%0d tos=%h ovf=%b expected 1,16,0f,1",
               u_if.full, u_if.count, u_if.tos, u_if.overflow);
    end
    u_if.clear_err = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (u_if.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: ovf=%b expected 0", u_if.overflow);
    end
    // Replace-top while full must not raise overflow.
    u_if.push = 1'b1;
    u_if.pop  = 1'b1;
    u_if.din  = 8'h55;
    tick();
    idle_inputs();
    tests_run++;
    if ({u_if.count, u_if.tos, u_if.overflow} !== {5'd16, 8'h55, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_replace: count=%0d tos=%h ovf=%b expected 16,55,0", u_if.count, u_if.tos, u_if.overflow);
    end
  endtask

  task automatic test_replace_top();
    do_reset();
    push_val(8'h05);
    push_val(8'h07);
    u_if.push = 1'b1;
    u_if.pop  = 1'b1;
    u_if.din  = 8'h0C;
    tick();
    idle_inputs();
    tests_run++;
    if ({u_if.count, u_if.tos, u_if.underflow} !== {5'd2, 8'h0C, 1'b0}) begin
      tests_failed++;
      $display("FAIL replace_top: count=%0d tos=%h unf=%b expected 2,0c,0", u_if.count, u_if.tos, u_if.underflow);
    end
`ifdef STACK_NOS_EN
    tests_run++;
    if ({u_if.nos, u_if.two_valid} !== {8'h05, 1'b1}) begin
      tests_failed++;
      $display("FAIL replace_nos: nos=%h two_valid=%b expected 05,1", u_if.nos, u_if.two_valid);
    end
`endif
    pop_one();
    tests_run++;
    if ({u_if.count, u_if.tos} !== {5'd1, 8'h05}) begin
      tests_failed++;
      $display("FAIL replace_below: count=%0d tos=%h expected 1,05", u_if.count, u_if.tos);
    end
`ifdef STACK_NOS_EN
    tests_run++;
    if ({u_if.nos, u_if.two_valid} !== {8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL nos_single: nos=%h two_valid=%b expected 00,0", u_if.nos, u_if.two_valid);
    end
`endif
  endtask

  task automatic test_simul_empty();
    do_reset();
    u_if.push = 1'b1;
    u_if.pop  = 1'b1;
    u_if.din  = 8'h09;
    tick();
    idle_inputs();
    tests_run++;
    if ({u_if.underflow, u_if.count, u_if.tos, u_if.overflow} !== {1'b1, 5'd1, 8'h09, 1'b0}) begin
      tests_failed++;
      $display("FAIL simul_empty: unf=%b count=%0d tos=%h ovf=%b expected 1,1,09,0",
               u_if.underflow, u_if.count, u_if.tos, u_if.overflow);
    end
    pop_one();
    tests_run++;
    if ({u_if.empty, u_if.underflow} !== {1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL simul_drain: empty=%b unf=%b expected 1,1", u_if.empty, u_if.underflow);
    end
    // Clear and a new underflow in the same cycle: the set wins.
    u_if.clear_err = 1'b1;
    u_if.pop       = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if ({u_if.underflow, u_if.count} !== {1'b1, 5'd0}) begin
      tests_failed++;
      $display("FAIL clear_vs_set: unf=%b count=%0d expected 1,0", u_if.underflow, u_if.count);
    end
    u_if.clear_err = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (u_if.underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_clear: unf=%b expected 0", u_if.underflow);
    end
  endtask

  task automatic test_zero_detect();
    do_reset();
    push_val(8'h00);
    tests_run++;
    if ({u_if.tos_zero, u_if.tos} !== {1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL zero_after_push0: tz=%b tos=%h expected 1,00", u_if.tos_zero, u_if.tos);
    end
    push_val(8'h01);
    tests_run++;
    if ({u_if.tos_zero, u_if.tos} !== {1'b0, 8'h01}) begin
      tests_failed++;
      $display("FAIL zero_after_push1: tz=%b tos=%h expected 0,01", u_if.tos_zero, u_if.tos);
    end
    pop_one();
    tests_run++;
    if (u_if.tos_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_after_pop1: tz=%b expected 1", u_if.tos_zero);
    end
    pop_one();
    tests_run++;
    if ({u_if.empty, u_if.tos_zero, u_if.tos} !== {1'b1, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL zero_empty: empty=%b tz=%b tos=%h expected 1,0,00", u_if.empty, u_if.tos_zero, u_if.tos);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    idle_inputs();
    test_reset();
    test_lifo();
    test_full_overflow();
    test_replace_top();
    test_simul_empty();
    test_zero_detect();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
